// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with single-cycle logic/arith ops and a WIDTH-cycle shift-add signed multiply.
// Define SEQ_ALU_MULHI_EN to add result_hi, the upper half of the signed multiply product.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef SEQ_ALU_MULHI_EN
    ,
    output logic [WIDTH-1:0] result_hi
`endif
);
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, FIN} state_t;

    state_t             state, state_nx;
    logic [2:0]         op_r;
    logic [WIDTH-1:0]   a_r, b_r, mag_a, mul_lo, alu_res;
    logic               neg, accept, shift_big;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     psum;
    logic [CW-1:0]      cnt;
`ifdef SEQ_ALU_MULHI_EN
    logic [2*WIDTH-1:0] mul_full;
`endif

    // busy stays high through the done cycle so the next acceptance waits one idle cycle
    assign busy   = (state != IDLE) || done;
    assign accept = start && !busy;
    assign psum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mag_a : '0)};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = (state == IDLE) ? (accept ? ((operation == OP_MUL) ? MUL : FIN) : IDLE) :
                   (state == MUL)  ? ((cnt == CW'(WIDTH - 1)) ? FIN : MUL) : IDLE;
    end

    always_comb begin
        shift_big = b_r >= WIDTH'(WIDTH);
`ifdef SEQ_ALU_MULHI_EN
        mul_full = neg ? -prod : prod;
        mul_lo   = mul_full[WIDTH-1:0];
`else
        mul_lo   = neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
`endif
        alu_res = '0;
        case (op_r)
            3'b000:  alu_res = a_r + b_r;
            3'b001:  alu_res = b_r - a_r;
            3'b010:  alu_res = a_r & b_r;
            3'b011:  alu_res = a_r | b_r;
            3'b100:  alu_res = mul_lo;
            3'b101:  alu_res = shift_big ? '0 : a_r << b_r;
            3'b110:  alu_res = shift_big ? '0 : a_r >> b_r;
            default: alu_res = WIDTH'($signed(b_r) < $signed(a_r));
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            prod   <= '0;
            cnt    <= '0;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            mag_a  <= '0;
            neg    <= 1'b0;
`ifdef SEQ_ALU_MULHI_EN
            result_hi <= '0;
`endif
        end else begin
            done <= (state == FIN);
            if (accept) begin
                op_r  <= operation;
                a_r   <= a;
                b_r   <= b;
                mag_a <= a[WIDTH-1] ? -a : a;
                prod  <= {{WIDTH{1'b0}}, (b[WIDTH-1] ? -b : b)};
                neg   <= a[WIDTH-1] ^ b[WIDTH-1];
                cnt   <= '0;
            end
            // shift-add: carry-extended upper half plus multiplier bits shifting out the bottom
            if (state == MUL) begin
                prod <= {psum, prod[WIDTH-1:1]};
                cnt  <= cnt + 1'b1;
            end
            if (state == FIN) begin
                result <= alu_res;
                zero   <= (alu_res == '0);
`ifdef SEQ_ALU_MULHI_EN
                result_hi <= (op_r == OP_MUL) ? mul_full[2*WIDTH-1:WIDTH] : '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed scoreboard bench for seq_alu (WIDTH=16); define SEQ_ALU_MULHI_EN to also check result_hi.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        reset, start, busy, done, zero;
    logic [2:0]  operation;
    logic [15:0] a, b, result;
`ifdef SEQ_ALU_MULHI_EN
    logic [15:0] result_hi;
`endif

    typedef struct {
        logic [15:0] r;
        logic        z;
        logic [15:0] hi;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .operation(operation),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .zero(zero)
`ifdef SEQ_ALU_MULHI_EN
        , .result_hi(result_hi)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got result 0x%0h with no pending operation (cycle %0d)", result, cyc);
            end else begin
                e = q.pop_front();
                chk("result", {16'h0, result}, {16'h0, e.r});
                chk("zero", {31'h0, zero}, {31'h0, e.z});
                chk("latency", cyc - e.acc, e.lat);
`ifdef SEQ_ALU_MULHI_EN
                chk("result_hi", {16'h0, result_hi}, {16'h0, e.hi});
`endif
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy still 1, expected 0 (cycle %0d)", cyc);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] er, input logic [15:0] ehi, input int lat);
        wait_idle();
        start = 1'b1; operation = op; a = ia; b = ib;
        q.push_back('{r: er, z: (er == 16'h0), hi: ehi, acc: cyc + 1, lat: lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; operation = 3'b000; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_result", {16'h0, result}, 32'h0);
        chk("rst_zero", {31'h0, zero}, 32'h1);
        reset = 1'b0;
        @(negedge clk);

        issue(3'b000, 16'h7FFF, 16'h0001, 16'h8000, 16'h0, 1);
        issue(3'b001, 16'd5,    16'd5,    16'h0000, 16'h0, 1);
        issue(3'b001, 16'd3,    16'd10,   16'h0007, 16'h0, 1);
        issue(3'b001, 16'd10,   16'd3,    16'hFFF9, 16'h0, 1);
        issue(3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0, 1);
        issue(3'b011, 16'hF0F0, 16'h3C3C, 16'hFCFC, 16'h0, 1);
        issue(3'b111, 16'h0001, 16'hFFFF, 16'h0001, 16'h0, 1);
        issue(3'b111, 16'hFFFF, 16'h0001, 16'h0000, 16'h0, 1);
        issue(3'b101, 16'h0001, 16'd16,   16'h0000, 16'h0, 1);
        issue(3'b101, 16'h0001, 16'd15,   16'h8000, 16'h0, 1);
        issue(3'b101, 16'h00FF, 16'd4,    16'h0FF0, 16'h0, 1);
        issue(3'b101, 16'h00FF, 16'hFFFF, 16'h0000, 16'h0, 1);
        issue(3'b110, 16'h8000, 16'd15,   16'h0001, 16'h0, 1);
        issue(3'b110, 16'hF000, 16'd4,    16'h0F00, 16'h0, 1);
        issue(3'b110, 16'hF000, 16'd16,   16'h0000, 16'h0, 1);

        // multiply with busy held for the whole operation including the done cycle
        issue(3'b100, 16'hFFFD, 16'd7, 16'hFFEB, 16'hFFFF, 17);
        for (int i = 0; i < 17; i++) begin
            chk("mul_busy", {31'h0, busy}, 32'h1);
            @(negedge clk);
        end
        issue(3'b100, 16'h7FFF, 16'h7FFF, 16'h0001, 16'h3FFF, 17);
        issue(3'b100, 16'h8000, 16'h8000, 16'h0000, 16'h4000, 17);
        issue(3'b100, 16'hFFFB, 16'hFFFA, 16'h001E, 16'h0000, 17);
        issue(3'b100, 16'h0000, 16'd123,  16'h0000, 16'h0000, 17);
        issue(3'b100, 16'h8000, 16'h0001, 16'h8000, 16'hFFFF, 17);

        // start pulse during a multiply must be ignored
        issue(3'b100, 16'd3, 16'hFFFC, 16'hFFF4, 16'hFFFF, 17);
        repeat (3) @(negedge clk);
        start = 1'b1; operation = 3'b000; a = 16'd2; b = 16'd2;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // start held high: second acceptance three cycles after the first
        wait_idle();
        start = 1'b1; operation = 3'b000; a = 16'd1; b = 16'd2;
        q.push_back('{r: 16'd3, z: 1'b0, hi: 16'h0, acc: cyc + 1, lat: 1});
        q.push_back('{r: 16'd3, z: 1'b0, hi: 16'h0, acc: cyc + 4, lat: 1});
        repeat (4) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // reset during multiply aborts it with no done pulse
        start = 1'b1; operation = 3'b100; a = 16'd9; b = 16'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mul_midbusy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        chk("abort_result", {16'h0, result}, 32'h0);
        chk("abort_zero", {31'h0, zero}, 32'h1);
        reset = 1'b0;
        repeat (25) @(negedge clk);

        chk("pending_ops", q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
